// File: rtl/apb_waitstate_completer.sv
// APB completer: byte register file behind one PSEL with a read-only ID byte at
// address 0, a fixed number of wait states per transfer, and PSLVERR on bad
// accesses. Read data and the error flag are resolved at the SETUP edge, so the
// ACCESS phase only has to count down and then finish the transfer.
module apb_waitstate_completer #(
    parameter int unsigned       ADDR_W      = 9,
    parameter int unsigned       DATA_W      = 8,
    parameter int unsigned       DEPTH       = 64,
    parameter int unsigned       WAIT_CYCLES = 2,
    parameter logic [DATA_W-1:0] ID_VALUE    = 'hA5
) (
    input  logic              pclk,
    input  logic              preset,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [ADDR_W-1:0] paddr,
    input  logic [DATA_W-1:0] pwdata,
    output logic [DATA_W-1:0] prdata,
    output logic              pready,
    output logic              pslverr
);

    localparam int unsigned     IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_L   = (ADDR_W + 1)'(DEPTH);
    localparam logic [3:0]      WAIT_L    = 4'(WAIT_CYCLES);

    localparam logic [0:0]      ST_IDLE   = 1'b0;
    localparam logic [0:0]      ST_ACCESS = 1'b1;

    logic [0:0]        state_q, state_d;
    logic [3:0]        cnt_q,   cnt_d;
    logic [ADDR_W-1:0] addr_q,  addr_d;
    logic              write_q, write_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              err_q,   err_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic              setup;
    logic              setup_err;
    logic [DATA_W-1:0] setup_rdata;
    logic              done;
    logic              commit;

    // A SETUP beat restarts the transfer in either state
    assign setup     = psel & ~penable;
    assign setup_err = ({1'b0, paddr} >= DEPTH_L) | (pwrite & (paddr == '0));

    // Read data resolved from the incoming address at the SETUP edge
    always_comb begin
        if (setup_err) begin
            setup_rdata = '0;
        end else if (paddr == '0) begin
            setup_rdata = ID_VALUE;
        end else begin
            setup_rdata = mem_q[paddr[IDX_W-1:0]];
        end
    end

    assign done   = (state_q == ST_ACCESS) & psel & penable & (cnt_q == '0);
    assign commit = done & write_q & ~err_q;

    // Transfer sequencing: capture on SETUP, count wait states, complete or abort
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        write_d = write_q;
        wdata_d = wdata_q;
        err_d   = err_q;
        rdata_d = rdata_q;
        if (setup) begin
            state_d = ST_ACCESS;
            cnt_d   = WAIT_L;
            addr_d  = paddr;
            write_d = pwrite;
            wdata_d = pwdata;
            err_d   = setup_err;
            rdata_d = setup_rdata;
        end else if (state_q == ST_ACCESS) begin
            if (!psel) begin
                state_d = ST_IDLE;
            end else if (cnt_q != '0) begin
                cnt_d = cnt_q - 4'd1;
            end else begin
                state_d = ST_IDLE;
            end
        end
    end

    // Control and captured-transfer registers
    always_ff @(posedge pclk) begin
        if (preset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            write_q <= write_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    // Register file; a write lands only on the completing ACCESS edge
    always_ff @(posedge pclk) begin
        if (preset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (commit) begin
            mem_q[addr_q[IDX_W-1:0]] <= wdata_q;
        end
    end

    assign pready  = (state_q == ST_ACCESS) & (cnt_q == '0);
    assign pslverr = pready & err_q;
    assign prdata  = rdata_q;

endmodule

// File: tb/tb_apb_waitstate_completer.sv
// Scoreboard bench for apb_waitstate_completer: the driver predicts each
// transfer's response from a plain byte-array model and queues it; a negedge
// monitor matches every PREADY pulse against the queue.
module tb_apb_waitstate_completer;

    parameter int W = 2;
    localparam int         DEPTH = 64;
    localparam logic [7:0] ID    = 8'hA5;

    logic       pclk = 1'b0;
    logic       preset = 1'b0;
    logic       psel = 1'b0;
    logic       penable = 1'b0;
    logic       pwrite = 1'b0;
    logic [8:0] paddr = '0;
    logic [7:0] pwdata = '0;
    logic [7:0] prdata;
    logic       pready;
    logic       pslverr;

    apb_waitstate_completer #(
        .ADDR_W     (9),
        .DATA_W     (8),
        .DEPTH      (DEPTH),
        .WAIT_CYCLES(W),
        .ID_VALUE   (ID)
    ) dut (
        .pclk   (pclk),
        .preset (preset),
        .psel   (psel),
        .penable(penable),
        .pwrite (pwrite),
        .paddr  (paddr),
        .pwdata (pwdata),
        .prdata (prdata),
        .pready (pready),
        .pslverr(pslverr)
    );

    always #5 pclk = ~pclk;

    int cyc = 0;
    always @(posedge pclk) cyc <= cyc + 1;

    typedef struct {
        int         due;
        bit         rd;
        logic [7:0] data;
        bit         err;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] model[512];
    int         checks = 0;
    int         errors = 0;
    bit         started = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every PREADY must match the oldest queued expectation
    always @(negedge pclk) begin
        if (started && !preset) begin
            if (pready) begin
                if (sb.size() == 0) begin
                    check("pready_unexpected", {31'b0, pready}, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("pready_latency", cyc, e.due);
                    check("pslverr", {31'b0, pslverr}, {31'b0, e.err});
                    if (e.rd) check("prdata", {24'b0, prdata}, {24'b0, e.data});
                end
            end else begin
                if (pslverr) check("pslverr_without_pready", {31'b0, pslverr}, 32'd0);
                if (sb.size() > 0 && cyc > sb[0].due) begin
                    check("pready_missing", {31'b0, pready}, 32'd1);
                    void'(sb.pop_front());
                end
            end
        end
    end

    function automatic exp_t predict(input bit wr, input logic [8:0] a, input int due);
        exp_t e;
        e.due  = due;
        e.rd   = !wr;
        e.err  = (int'(a) >= DEPTH) || (wr && a == 0);
        e.data = e.err ? 8'h00 : (a == 0) ? ID : model[a];
        return e;
    endfunction

    function automatic void clear_model();
        foreach (model[i]) model[i] = 8'h00;
    endfunction

    task automatic drive_setup(input bit wr, input logic [8:0] a, input logic [7:0] d);
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
        @(negedge pclk);
        penable = 1'b1;
    endtask

    // Full or aborted transfer; abort_after = ACCESS edges before psel drops
    task automatic xfer(input bit wr, input logic [8:0] a, input logic [7:0] d,
                        input int abort_after);
        if (abort_after < 0) begin
            exp_t e;
            e = predict(wr, a, cyc + 1 + W);
            sb.push_back(e);
            if (wr && !e.err) model[a] = d;
        end
        drive_setup(wr, a, d);
        if (abort_after < 0) begin
            repeat (W + 1) @(negedge pclk);
        end else begin
            repeat (abort_after) @(negedge pclk);
            psel = 1'b0; penable = 1'b0;
            @(negedge pclk);
        end
    endtask

    task automatic do_reset();
        preset = 1'b1; psel = 1'b0; penable = 1'b0;
        @(negedge pclk);
        check("reset_prdata", {24'b0, prdata}, 32'd0);
        check("reset_pready", {31'b0, pready}, 32'd0);
        check("reset_pslverr", {31'b0, pslverr}, 32'd0);
        sb.delete();
        clear_model();
        preset = 1'b0;
    endtask

    // Reset arrives on the edge right after SETUP; nothing may commit
    task automatic xfer_reset(input bit wr, input logic [8:0] a, input logic [7:0] d);
        if (W == 0) sb.push_back(predict(wr, a, cyc + 1));
        drive_setup(wr, a, d);
        do_reset();
    endtask

    task automatic idle(input int n);
        psel = 1'b0; penable = 1'b0;
        repeat (n) @(negedge pclk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        clear_model();
        @(negedge pclk);
        started = 1'b1;
        do_reset();
        idle(2);

        // Basic write/read with wait states
        xfer(1'b1, 9'd5, 8'h3C, -1);
        xfer(1'b0, 9'd5, 8'h00, -1);
        idle(1);
        // ID register: readable, write errors, value unchanged
        xfer(1'b0, 9'd0, 8'h00, -1);
        xfer(1'b1, 9'd0, 8'h11, -1);
        xfer(1'b0, 9'd0, 8'h00, -1);
        // Out-of-range accesses
        xfer(1'b1, 9'd64, 8'h5A, -1);
        xfer(1'b0, 9'h1FF, 8'h00, -1);
        // Back-to-back writes then reads
        xfer(1'b1, 9'd1, 8'h01, -1);
        xfer(1'b1, 9'd2, 8'h02, -1);
        xfer(1'b0, 9'd1, 8'h00, -1);
        xfer(1'b0, 9'd2, 8'h00, -1);
        idle(1);
        // Aborted write leaves memory untouched
        if (W > 0) xfer(1'b1, 9'd7, 8'hFF, W - 1);
        xfer(1'b0, 9'd7, 8'h00, -1);
        idle(1);
        // Reset in the middle of a write, then a normal transfer
        xfer(1'b1, 9'd3, 8'h66, -1);
        xfer_reset(1'b1, 9'd3, 8'h77);
        xfer(1'b0, 9'd3, 8'h00, -1);
        xfer(1'b1, 9'd4, 8'h44, -1);
        xfer(1'b0, 9'd4, 8'h00, -1);
        idle(2);

        for (int n = 0; n < 400; n++) begin
            int         r;
            bit         wr;
            logic [8:0] a;
            logic [7:0] d;
            r  = int'($urandom_range(0, 99));
            wr = 1'($urandom_range(0, 1));
            d  = 8'($urandom);
            case ($urandom_range(0, 9))
                0:       a = 9'd0;
                1:       a = 9'($urandom_range(DEPTH, 511));
                default: a = 9'($urandom_range(1, DEPTH - 1));
            endcase
            if (r < 3)
                xfer_reset(wr, a, d);
            else if (r < 12 && W > 0)
                xfer(wr, a, d, int'($urandom_range(0, W - 1)));
            else
                xfer(wr, a, d, -1);
            if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 2)));
        end

        idle(W + 3);
        check("scoreboard_drained", sb.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
